// File: rtl/reg_write_arbiter.sv
// ============================================================================
// reg_write_arbiter : round-robin arbiter driving one shared register's en/in
// Optional lock extension enabled by macro ARB_LOCK_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module reg_write_arbiter #(
    parameter int WIDTH    = 8,
    parameter int NUM_REQ  = 4,
    parameter int LOCK_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         lock,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       reg_en,
    output logic [WIDTH-1:0]           reg_in
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [NUM_REQ-1:0] elig;
    logic [PTR_W-1:0]   start;
    logic [PTR_W-1:0]   idx;
    logic [PTR_W-1:0]   win;
    logic               found;
    logic               hold;

    logic [WIDTH-1:0]   data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] k);
        return (k == PTR_W'(NUM_REQ - 1)) ? '0 : k + 1'b1;
    endfunction

`ifdef ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    logic [PTR_W-1:0] cur_idx;
    logic [CNT_W-1:0] lock_cnt;
`else
    logic unused_lock;
    assign unused_lock = ^{lock, 1'(LOCK_MAX)};
`endif

    // The current grantee is excluded so a requester dropping req at the end
    // of its grant cycle can never be granted twice.
    always_comb begin
        elig  = req & ~gnt;
        start = ptr;
        hold  = 1'b0;
`ifdef ARB_LOCK_EN
        if (reg_en && lock[cur_idx] && req[cur_idx]) begin
            if (lock_cnt < CNT_W'(LOCK_MAX)) begin
                hold = 1'b1;
            end else begin
                start = next_idx(cur_idx);
            end
        end
`endif
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = PTR_W'((int'(start) + j) % NUM_REQ);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
`ifdef ARB_LOCK_EN
        if (hold) begin
            found = 1'b1;
            win   = cur_idx;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            gnt    <= '0;
            reg_en <= 1'b0;
            reg_in <= '0;
            ptr    <= '0;
`ifdef ARB_LOCK_EN
            cur_idx  <= '0;
            lock_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE:    state <= found ? GRANT : IDLE;
                GRANT:   state <= found ? GRANT : IDLE;
                default: state <= IDLE;
            endcase

            if (found) begin
                gnt    <= ONE << win;
                reg_en <= 1'b1;
                reg_in <= data_arr[win];
                if (!hold) begin
                    ptr <= next_idx(win);
                end
            end else begin
                gnt    <= '0;
                reg_en <= 1'b0;
                // start differs from ptr only after a forced lock release
                ptr    <= start;
            end
`ifdef ARB_LOCK_EN
            if (found) begin
                cur_idx  <= win;
                lock_cnt <= hold ? lock_cnt + 1'b1 : CNT_W'(1);
            end else begin
                lock_cnt <= '0;
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// ============================================================================
// tb_reg_write_arbiter : directed + random check of reg_write_arbiter against
// a grant-index reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_reg_write_arbiter;

    localparam int WIDTH    = 8;
    localparam int NUM_REQ  = 4;
    localparam int LOCK_MAX = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req = '0;
    logic [NUM_REQ*WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]       lock = '0;
    logic [NUM_REQ-1:0]       gnt;
    logic                     reg_en;
    logic [WIDTH-1:0]         reg_in;
    logic [WIDTH-1:0]         reg_out;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int               m_cur = -1;
    int               m_ptr = 0;
    int               m_cnt = 0;
    logic [WIDTH-1:0] m_in  = '0;
    logic [WIDTH-1:0] m_out = '0;

    reg_write_arbiter #(
        .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .lock(lock),
        .gnt(gnt), .reg_en(reg_en), .reg_in(reg_in)
    );

    always #5 clk = ~clk;

    // shared register fed by the arbiter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) reg_out <= '0;
        else if (reg_en) reg_out <= reg_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cur = -1; m_ptr = 0; m_cnt = 0; m_in = '0; m_out = '0;
    endtask

    task automatic model_edge();
        int  win   = -1;
        bit  hold  = 1'b0;
        int  start = m_ptr;
`ifdef ARB_LOCK_EN
        if (m_cur >= 0 && lock[m_cur] && req[m_cur]) begin
            if (m_cnt < LOCK_MAX) hold = 1'b1;
            else start = (m_cur + 1) % NUM_REQ;
        end
`endif
        if (m_cur >= 0) m_out = m_in;
        if (hold) win = m_cur;
        else begin
            for (int j = 0; j < NUM_REQ; j++) begin
                int i;
                i = (start + j) % NUM_REQ;
                if (win < 0 && req[i] && i != m_cur) win = i;
            end
        end
        if (win >= 0) begin
            m_cnt = hold ? m_cnt + 1 : 1;
            if (!hold) m_ptr = (win + 1) % NUM_REQ;
            m_in = req_data[win*WIDTH +: WIDTH];
        end else begin
            m_cnt = 0;
            m_ptr = start;
        end
        m_cur = win;
    endtask

    function automatic logic [NUM_REQ-1:0] exp_gnt();
        logic [NUM_REQ-1:0] g;
        g = '0;
        if (m_cur >= 0) g[m_cur] = 1'b1;
        return g;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("gnt",     32'(gnt),     32'(exp_gnt()));
        chk("reg_en",  32'(reg_en),  32'(m_cur >= 0));
        chk("reg_in",  32'(reg_in),  32'(m_in));
        chk("reg_out", 32'(reg_out), 32'(m_out));
    endtask

    initial begin
        logic [NUM_REQ-1:0] seq [5];
        logic [WIDTH-1:0]   dseq [5];

        // power-on reset
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("rst_gnt",    32'(gnt),    32'h0);
        chk("rst_reg_en", 32'(reg_en), 32'h0);
        chk("rst_reg_in", 32'(reg_in), 32'h0);
        @(negedge clk) rst = 1'b1;

        // single requester: alternate-cycle grants
        req = 4'b0001;
        req_data = {8'h00, 8'h00, 8'h00, 8'h5A};
        tick();
        chk("single_gnt",  32'(gnt),    32'h1);
        chk("single_data", 32'(reg_in), 32'h5A);
        tick();
        chk("single_gap",  32'(gnt),     32'h0);
        chk("single_out",  32'(reg_out), 32'h5A);
        tick();
        chk("single_again", 32'(gnt), 32'h1);

        // reset asserted mid-grant
        req = 4'b1111;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        tick();
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("midrst_gnt",    32'(gnt),    32'h0);
        chk("midrst_reg_en", 32'(reg_en), 32'h0);
        chk("midrst_reg_in", 32'(reg_in), 32'h0);
        @(negedge clk) rst = 1'b1;

        // full contention from ptr=0
        seq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        dseq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("cont_gnt", 32'(gnt),    32'(seq[i]));
            chk("cont_in",  32'(reg_in), 32'(dseq[i]));
            chk("cont_en",  32'(reg_en), 32'h1);
        end
        tick(); tick(); tick();
        chk("wrap_pre", 32'(gnt), 32'h8);

        // pointer wrap after grant to index 3
        req = 4'b1010;
        tick();
        chk("wrap_gnt1", 32'(gnt), 32'h2);
        tick();
        chk("wrap_gnt3", 32'(gnt), 32'h8);
        chk("wrap_in",   32'(reg_in), 32'h13);

        // idle hold
        req = 4'b0000;
        tick();
        chk("idle_gnt", 32'(gnt),    32'h0);
        chk("idle_en",  32'(reg_en), 32'h0);
        chk("idle_in",  32'(reg_in), 32'h13);
        req = 4'b1111;
        tick();
        chk("idle_resume", 32'(gnt), 32'h1);

        // lock behaviour on req=0101 with lock[2]
        req  = 4'b0101;
        lock = 4'b0100;
`ifdef ARB_LOCK_EN
        seq = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
`else
        seq = '{4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100};
`endif
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("lock_gnt", 32'(gnt), 32'(seq[i]));
        end
        lock = '0;

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            req      = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
            lock     = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
            req_data = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
